// File: rtl/demultiplex_3bit.sv
// Routes one 32-bit word to one of seven registered destinations.
// A one-entry hold buffer absorbs a busy destination and back-pressures the producer.
module demultiplex_3bit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic [2:0]  in_sel,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  dst_busy,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [31:0] out_c,
    output logic [31:0] out_d,
    output logic [31:0] out_e,
    output logic [31:0] out_f,
    output logic [31:0] out_g,
    output logic [6:0]  out_wr,
    output logic        sel_err,
    output logic [7:0]  err_count
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_hold_data;
    logic [2:0]  r_hold_sel;
    logic [31:0] r_out [7];

    logic [7:0]  w_busy8;
    logic        w_accept;
    logic        w_wr_en;
    logic [2:0]  w_wr_sel;
    logic [31:0] w_wr_data;
    logic [6:0]  w_wr_onehot;
    logic        w_err;
    logic        w_capture;

    // Pad busy so code 111 indexes a defined bit
    assign w_busy8  = {1'b0, dst_busy};
    assign in_ready = (r_state == IDLE) && !reset;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_next    = r_state;
        w_wr_en   = 1'b0;
        w_wr_sel  = r_hold_sel;
        w_wr_data = r_hold_data;
        w_err     = 1'b0;
        w_capture = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (in_sel == 3'b111) begin
                        w_err = 1'b1;
                    end else if (!w_busy8[in_sel]) begin
                        w_wr_en   = 1'b1;
                        w_wr_sel  = in_sel;
                        w_wr_data = in_data;
                    end else begin
                        w_capture = 1'b1;
                        w_next    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!w_busy8[r_hold_sel]) begin
                    w_wr_en = 1'b1;
                    w_next  = IDLE;
                end
            end
        endcase
    end

    assign w_wr_onehot = w_wr_en ? (7'b1 << w_wr_sel) : 7'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_hold_data <= 32'd0;
            r_hold_sel  <= 3'd0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_hold_data <= in_data;
                r_hold_sel  <= in_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 7; i++) begin
                r_out[i] <= 32'd0;
            end
            out_wr    <= 7'd0;
            sel_err   <= 1'b0;
            err_count <= 8'd0;
        end else begin
            out_wr  <= w_wr_onehot;
            sel_err <= w_err;
            for (int i = 0; i < 7; i++) begin
                if (w_wr_onehot[i]) begin
                    r_out[i] <= w_wr_data;
                end
            end
            if (w_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    assign out_a = r_out[0];
    assign out_b = r_out[1];
    assign out_c = r_out[2];
    assign out_d = r_out[3];
    assign out_e = r_out[4];
    assign out_f = r_out[5];
    assign out_g = r_out[6];

endmodule

// File: doc/demultiplex_3bit.md
# demultiplex_3bit

Write-side counterpart of the datapath's 3-bit-select 32-bit multiplexers. It takes one 32-bit word plus a 3-bit destination code and writes the word into one of seven registered destination outputs (codes 000-110), each with a one-cycle write strobe. Each destination can stall with a busy flag. While stalled, the block holds the word in a one-entry buffer and back-pressures the producer with a valid/ready handshake. It sits between a producer (ALU result / memory data path) and the destination registers that are later read back through the select muxes.

## Interface
- No parameters. Data width is fixed at 32 bits and the destination count at 7.
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- in_data  in  32  word to distribute
- in_sel  in  3  destination code: 000→out_a … 110→out_g; 111 is illegal
- in_valid  in  1  producer has a word
- in_ready  out  1  block can accept a word; transfer occurs when in_valid && in_ready at a rising edge
- dst_busy  in  7  bit i high means destination i cannot take a write this cycle
- out_a … out_g  out  32 each  registered destination values
- out_wr  out  7  one-hot, registered; bit i high for one cycle when out_(i) is updated
- sel_err  out  1  registered one-cycle pulse on an accepted word with in_sel=111
- err_count  out  8  saturating count of illegal-select words

## Operation
- Reset values: out_a…out_g=0, out_wr=0, sel_err=0, err_count=0, and the hold buffer is cleared. The state machine is forced to IDLE. in_ready is 0 while reset is high.
- State machine has two states, IDLE and HOLD. in_ready = (state==IDLE) && !reset.
- In IDLE, when a word is accepted with in_sel=s:
  - s=111: the word is dropped. sel_err=1 next cycle. err_count increments and saturates at 255. State stays IDLE.
  - s≤110 and dst_busy[s]=0 at the accepting edge: out_(s) ← in_data and out_wr[s]=1 next cycle. State stays IDLE.
  - s≤110 and dst_busy[s]=1: in_data and s are captured into the hold buffer. State goes to HOLD. No strobe is issued.
- In HOLD:
  - in_ready=0, and in_data/in_sel are ignored.
  - At each edge, dst_busy[held_sel] is sampled. If it is 0, out_(held_sel) ← held_data, out_wr[held_sel]=1 next cycle, and state goes to IDLE. If it is 1, the block stays in HOLD indefinitely with no timeout.
- Only dst_busy of the addressed destination matters. Other busy bits are ignored.
- Destinations that are not written keep their value. At most one out_wr bit is high in any cycle, and out_wr and sel_err are never high together.
- Reset asserted mid-HOLD discards the pending word. No strobe is issued for it.

## Timing
- Write latency is 1 edge. out_(s) changes at the same edge that out_wr[s] rises, so the strobe and the new data are aligned for the whole cycle.
- With busy low, throughput is one word per cycle. Back-to-back accepts to the same destination give consecutive strobes and consecutive values.
- A stall of N cycles makes the write land at the first edge where busy is sampled low. in_ready returns high in the cycle after that write. This gives exactly one bubble on the producer side after any stall.
- sel_err and the err_count increment take effect at the edge following the accept.
- in_ready depends only on state and reset, with no combinational path from in_valid, in_sel or dst_busy.

## Test plan
- Reset → all outputs 0 and in_ready=0. After reset is released → in_ready=1.
- Write 0x0000_00AA to sel=000, then 0x1234_5678 to sel=110, back-to-back with busy=0 → out_a=0x0000_00AA with out_wr=0000001, then out_g=0x1234_5678 with out_wr=1000000. All other outputs stay 0.
- sel=011 with dst_busy[3]=1 for 3 cycles, data 0xDEAD_BEEF, and a second word presented during the stall → in_ready=0 for the stall cycles. out_d=0xDEAD_BEEF with out_wr[3] on the edge after busy drops. One bubble follows, then the second word is accepted.
- sel=101 with dst_busy[2]=1 and all other busy bits 0 → write to out_f is immediate with no stall.
- 257 words with sel=111 → sel_err pulses on each one, err_count saturates at 255, and no out_wr or out_* change occurs.
- Reset asserted while in HOLD (sel=001, busy=1) → pending word is lost, out_b stays 0, and no out_wr[1] pulse occurs after reset is released.
